// File: rtl/poly_disp_scan.sv
// rtl/poly_disp_scan.sv - polyphonic voice scanner building a held/clamped note display frame
module poly_disp_scan #(
    parameter int VOICES      = 16,
    parameter int SLOT_W      = 16,
    parameter int NOTE_BASE   = 36,
    parameter int HOLD_FRAMES = 8,
    parameter int IDX_W       = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    output logic [IDX_W-1:0]           sel_idx,
    input  logic                       note_on_in,
    input  logic [6:0]                 note_in,
    output logic [VOICES*SLOT_W-1:0]   pd_out,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);
    localparam int HC_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam int ST_W = IDX_W + 1;
    localparam int NSEL = 1 << IDX_W;
    localparam logic [ST_W-1:0]  STEP_LAST = ST_W'(VOICES);
    localparam logic [ST_W-1:0]  STEP_PEN  = ST_W'(VOICES - 1);
    localparam logic [IDX_W-1:0] SEL_LAST  = IDX_W'(VOICES - 1);
    localparam logic [HC_W-1:0]  HOLD_INIT = HC_W'(HOLD_FRAMES);
    localparam logic [7:0]       NB        = 8'(NOTE_BASE);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;

    state_t                     r_state;
    logic [ST_W-1:0]            r_step;
    logic [VOICES*SLOT_W-1:0]   r_shadow;
    logic [6:0]                 r_last [NSEL];
    logic [HC_W-1:0]            r_hold [NSEL];

    logic [IDX_W-1:0]           w_vidx;
    logic [IDX_W-1:0]           w_sel_nxt;
    logic                       w_sample;
    logic [6:0]                 w_note;
    logic                       w_clamp;
    logic [6:0]                 w_disp;
    logic                       w_held;
    logic [SLOT_W-1:0]          w_slot;
    logic [VOICES*SLOT_W-1:0]   w_shadow_nxt;

    // Data arriving now belongs to the index presented on the previous cycle.
    assign w_vidx    = IDX_W'(r_step - ST_W'(1));
    assign w_sel_nxt = (r_step < STEP_PEN) ? IDX_W'(r_step + ST_W'(1)) : SEL_LAST;
    assign w_sample  = (r_state == S_SCAN) && (r_step != '0);

    assign w_note  = note_on_in ? note_in : r_last[w_vidx];
    assign w_clamp = ({1'b0, w_note} < NB);
    assign w_disp  = w_clamp ? 7'd0 : (w_note - NB[6:0]);
    assign w_held  = !note_on_in && (r_hold[w_vidx] != '0);
    assign w_slot  = (note_on_in || w_held) ?
                     SLOT_W'({w_held, note_on_in, w_clamp, 1'b0, w_disp}) : '0;

    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_vidx <= SEL_LAST)
            w_shadow_nxt[w_vidx*SLOT_W +: SLOT_W] = w_slot;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_shadow <= '0;
            sel_idx  <= '0;
            pd_out   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
            for (int i = 0; i < NSEL; i++) begin
                r_last[i] <= '0;
                r_hold[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            overrun <= start && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_SCAN;
                        r_step  <= '0;
                        sel_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_sample) begin
                        r_shadow <= w_shadow_nxt;
                        if (note_on_in) begin
                            r_last[w_vidx] <= note_in;
                            r_hold[w_vidx] <= HOLD_INIT;
                        end else if (r_hold[w_vidx] != '0) begin
                            r_hold[w_vidx] <= r_hold[w_vidx] - HC_W'(1);
                        end
                    end
                    // Last voice is merged straight into the committed frame.
                    if (r_step == STEP_LAST) begin
                        r_state <= S_COMMIT;
                        pd_out  <= w_shadow_nxt;
                        done    <= 1'b1;
                    end else begin
                        r_step  <= r_step + ST_W'(1);
                        sel_idx <= w_sel_nxt;
                    end
                end
                S_COMMIT: begin
                    r_state <= S_IDLE;
                    sel_idx <= '0;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_disp_scan.sv
// tb/tb_poly_disp_scan.sv - directed table-driven bench for poly_disp_scan
module tb_poly_disp_scan;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, start_a, start_b;
    logic [4:0]   sel_a;
    logic [1:0]   sel_b;
    logic [4:0]   sel_q_a = '0;
    logic [1:0]   sel_q_b = '0;
    logic         on_a [32];
    logic [6:0]   nt_a [32];
    logic         on_b [4];
    logic [6:0]   nt_b [4];
    logic         non_a, non_b;
    logic [6:0]   nin_a, nin_b;
    logic [255:0] pd_a;
    logic [63:0]  pd_b;
    logic         busy_a, done_a, ovr_a, busy_b, done_b, ovr_b;

    int n_tests = 0;
    int n_fail  = 0;

    always @(posedge clk) begin
        sel_q_a <= sel_a;
        sel_q_b <= sel_b;
    end
    assign non_a = on_a[sel_q_a];
    assign nin_a = nt_a[sel_q_a];
    assign non_b = on_b[sel_q_b];
    assign nin_b = nt_b[sel_q_b];

    poly_disp_scan #(.VOICES(16), .SLOT_W(16), .NOTE_BASE(36), .HOLD_FRAMES(2), .IDX_W(5)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .sel_idx(sel_a),
        .note_on_in(non_a), .note_in(nin_a), .pd_out(pd_a),
        .busy(busy_a), .done(done_a), .overrun(ovr_a));

    poly_disp_scan #(.VOICES(4), .SLOT_W(16), .NOTE_BASE(36), .HOLD_FRAMES(0), .IDX_W(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .sel_idx(sel_b),
        .note_on_in(non_b), .note_in(nin_b), .pd_out(pd_b),
        .busy(busy_b), .done(done_b), .overrun(ovr_b));

    typedef struct {
        logic        on0;
        logic [6:0]  n0;
        logic        on3;
        logic [6:0]  n3;
        logic        on5;
        logic [6:0]  n5;
        logic [15:0] e0;
        logic [15:0] e3;
        logic [15:0] e5;
        int          rej_at;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [15:0] e0, input logic [15:0] e3, input logic [15:0] e5);
        logic [255:0] r;
        r = '0;
        r[15:0]  = e0;
        r[63:48] = e3;
        r[95:80] = e5;
        return r;
    endfunction

    task automatic load_a(input vec_t v);
        for (int i = 0; i < 32; i++) begin
            on_a[i] = 1'b0;
            nt_a[i] = 7'd99;
        end
        on_a[0] = v.on0; nt_a[0] = v.n0;
        on_a[3] = v.on3; nt_a[3] = v.n3;
        on_a[5] = v.on5; nt_a[5] = v.n5;
    endtask

    // Start is raised in the cycle before k=1; done is expected in cycle 18.
    task automatic run_a(input vec_t v, input logic [255:0] prev);
        int dn, ov, lat;
        logic [255:0] expd;
        expd = mk(v.e0, v.e3, v.e5);
        load_a(v);
        dn = 0; ov = 0; lat = 0;
        start_a = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (done_a) begin
                dn++;
                if (lat == 0) lat = k;
            end
            if (ovr_a) ov++;
            if (k == 1)  chk("busy_scan", busy_a, 1);
            if (k == 17) chk("pd_stable_scan", pd_a, prev);
            if (k == 18) chk("pd_commit", pd_a, expd);
            if (v.rej_at != 0 && k == v.rej_at + 1) chk("overrun_pulse", ovr_a, 1);
            if (k == 19) chk("busy_idle", busy_a, 0);
            start_a = (k == v.rej_at);
        end
        start_a = 1'b0;
        chk("latency", lat, 18);
        chk("done_count", dn, 1);
        chk("overrun_count", ov, (v.rej_at != 0) ? 1 : 0);
    endtask

    task automatic run_b(input logic [3:0] on, input logic [6:0] n2, input logic [63:0] expd);
        int dn, lat;
        for (int i = 0; i < 4; i++) begin
            on_b[i] = on[i];
            nt_b[i] = 7'd99;
        end
        nt_b[2] = n2;
        nt_b[1] = 7'd36;
        dn = 0; lat = 0;
        start_b = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (done_b) begin
                dn++;
                if (lat == 0) lat = k;
                chk("b_pd_commit", pd_b, expd);
            end
        end
        chk("b_latency", lat, 6);
        chk("b_done_count", dn, 1);
    endtask

    initial begin
        int dn;
        vecs[0] = '{1'b1, 7'd60, 1'b0, 7'd99, 1'b1, 7'd48, 16'h0218, 16'h0000, 16'h020C, 0};
        vecs[1] = '{1'b0, 7'd99, 1'b1, 7'd20, 1'b0, 7'd99, 16'h0418, 16'h0300, 16'h040C, 0};
        vecs[2] = '{1'b0, 7'd99, 1'b0, 7'd99, 1'b0, 7'd99, 16'h0418, 16'h0500, 16'h040C, 5};
        vecs[3] = '{1'b0, 7'd99, 1'b0, 7'd99, 1'b0, 7'd99, 16'h0000, 16'h0500, 16'h0000, 18};
        vecs[4] = '{1'b1, 7'd36, 1'b1, 7'd35, 1'b1, 7'd127, 16'h0200, 16'h0300, 16'h025B, 0};
        vecs[5] = '{1'b1, 7'd0, 1'b0, 7'd99, 1'b1, 7'd37, 16'h0300, 16'h0500, 16'h0201, 0};

        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 32; i++) begin on_a[i] = 1'b0; nt_a[i] = 7'd0; end
        for (int i = 0; i < 4; i++) begin on_b[i] = 1'b0; nt_b[i] = 7'd0; end
        repeat (2) @(negedge clk);
        chk("rst_pd", pd_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_overrun", ovr_a, 0);
        chk("rst_sel", sel_a, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_a(vecs[i], (i == 0) ? 256'd0 : mk(vecs[i-1].e0, vecs[i-1].e3, vecs[i-1].e5));

        // Abort a scan with reset at cycle 10.
        load_a(vecs[0]);
        start_a = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        chk("abort_pd", pd_a, 0);
        chk("abort_busy", busy_a, 0);
        chk("abort_sel", sel_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_a) dn++;
        end
        chk("abort_no_done", dn, 0);
        run_a(vecs[0], 256'd0);

        run_b(4'b0110, 7'd50, 64'h0000_020E_0200_0000);
        run_b(4'b0000, 7'd50, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/poly_disp_scan.md
POLY_DISP_SCAN -- requirements
Module: poly_disp_scan

Interface
REQ-001 Parameter VOICES, default 16: number of voice slots packed per frame (2..32).
REQ-002 Parameter SLOT_W, default 16: bits per slot (minimum 11).
REQ-003 Parameter NOTE_BASE, default 36: MIDI note shown as display value 0.
REQ-004 Parameter HOLD_FRAMES, default 8: frames a released voice stays displayed; 0 disables hold.
REQ-005 Parameter IDX_W, default 5: voice-select width; SHALL satisfy 2^IDX_W >= VOICES.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle frame-scan request.
REQ-009 sel_idx  output  IDX_W  voice currently addressed at the source.
REQ-010 note_on_in  input  1  gate of the voice addressed by sel_idx on the previous cycle.
REQ-011 note_in  input  7  MIDI note of that voice, same timing as note_on_in.
REQ-012 pd_out  output  VOICES*SLOT_W  committed display frame; slot v occupies bits [v*SLOT_W +: SLOT_W].
REQ-013 busy  output  1  high while a scan or commit is in progress.
REQ-014 done  output  1  one-cycle pulse on the commit cycle.
REQ-015 overrun  output  1  one-cycle pulse when start is rejected.

Function
REQ-016 FSM states IDLE, SCAN, COMMIT; IDLE -> SCAN on start; SCAN -> COMMIT after last voice sampled; COMMIT -> IDLE unconditionally after one cycle.
REQ-017 In SCAN, sel_idx SHALL step 0,1,..,VOICES-1 one per cycle, then hold VOICES-1; source data SHALL be sampled one cycle after each index, so SCAN lasts VOICES+1 cycles.
REQ-018 Slot format: bit 9 = active (note_on_in), bit 10 = held, bit 8 = clamp flag, bits 6:0 = display note, bit 7 and bits above 10 zero.
REQ-019 Display note = note_in - NOTE_BASE when note_in >= NOTE_BASE; otherwise 0 with clamp flag set; subtraction SHALL be unsigned, no wrap.
REQ-020 Each voice keeps a last-note register and a hold counter (width sufficient for HOLD_FRAMES).
REQ-021 Sampled note_on_in=1: slot active, last-note <= note_in, counter <= HOLD_FRAMES, held=0.
REQ-022 Sampled note_on_in=0 and counter>0: slot uses last-note, held=1, active=0, counter decrements by 1.
REQ-023 Sampled note_on_in=0 and counter=0: slot all zeros.
REQ-024 Slots SHALL be built in a shadow register; pd_out changes only on the COMMIT cycle, all slots at once.
REQ-025 done SHALL assert exactly in COMMIT; busy SHALL be high in SCAN and COMMIT, low in IDLE.
REQ-026 start while busy SHALL be ignored and SHALL pulse overrun the following cycle; start in COMMIT counts as rejected.
REQ-027 start and done never coincide with acceptance; a start in the first IDLE cycle after COMMIT SHALL be accepted.
REQ-028 Total latency start -> done SHALL be VOICES+2 cycles.

Reset
REQ-029 reset_n low SHALL immediately force: state IDLE, sel_idx 0, pd_out 0, shadow 0, all hold counters and last-notes 0, busy/done/overrun 0.
REQ-030 reset_n asserted mid-scan SHALL abort the frame; pd_out SHALL read 0, no done pulse.
REQ-031 After reset_n deasserts, first start is accepted on the next rising edge.

Verification
REQ-032 VOICES=16; voice 0 on note 60, voice 5 on note 48, rest off; start -> done at cycle 18, slot0=0x0218, slot5=0x020C, others 0.
REQ-033 Voice 3 note 20 on -> slot3=0x0300 (active+clamp, note 0).
REQ-034 Voice 0 note 60 released after frame 1, HOLD_FRAMES=2 -> frames 2,3 slot0=0x0418, frame 4 slot0=0x0000.
REQ-035 start pulsed at cycle 5 of a scan -> overrun pulse at cycle 6, single done, frame contents unchanged.
REQ-036 reset_n low at cycle 10 of scan -> pd_out=0, busy=0, no done; next start completes a normal frame.
REQ-037 HOLD_FRAMES=0; release voice 2 -> slot2=0x0000 on the very next frame.
